// File: rtl/sprite_rom_arbiter_if.sv
// Bus between the sprite fetchers, the arbiter and the single sprite ROM.
// The arbiter uses the slave modport; requesters and the ROM sit on the master side.
interface sprite_rom_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic                    rom_en;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;

    modport slave (
        input  req, lock, req_addr, rom_data,
        output gnt, rom_en, rom_addr, rvalid, rdata
    );

    modport master (
        output req, lock, req_addr, rom_data,
        input  gnt, rom_en, rom_addr, rvalid, rdata
    );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter with burst locking in front of the shared sprite ROM.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_frame,
    sprite_rom_arbiter_if.slave bus
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IdxW-1:0]   own_idx_q, own_idx_d;
    logic              own_vld_q, own_vld_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [N_REQ-1:0]  v1_q, v1_d;
    logic [N_REQ-1:0]  v2_q, v2_d;
    logic [IdxW-1:0]   scan_start;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    assign scan_start = '0;
`else
    logic [IdxW-1:0] ptr_q, ptr_d;
    assign scan_start = ptr_q;
`endif

    logic              own_hit;
    logic              rr_found;
    logic [IdxW-1:0]   rr_idx;
    logic [IdxW-1:0]   cand_idx;
    int unsigned       cand;
    logic              win_vld;
    logic [IdxW-1:0]   win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [N_REQ-1:0]  gnt;

    always_comb begin
        gnt      = '0;
        win_vld  = 1'b0;
        win_idx  = '0;
        win_addr = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;

        own_hit = own_vld_q && bus.req[own_idx_q] && bus.lock[own_idx_q] &&
                  (32'(bcnt_q) < MAX_BURST);

        // While an owner exists the pointer already sits past it, so a released
        // owner is naturally scanned last.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand     = (32'(scan_start) + k) % N_REQ;
            cand_idx = IdxW'(cand);
            if (!rr_found && bus.req[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end

        if (own_hit) begin
            win_vld = 1'b1;
            win_idx = own_idx_q;
        end else if (rr_found) begin
            win_vld = 1'b1;
            win_idx = rr_idx;
        end

        if (win_vld) gnt[win_idx] = 1'b1;

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == IdxW'(i)) win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        own_vld_d  = own_hit;
        own_idx_d  = own_idx_q;
        bcnt_d     = bcnt_q;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        rom_en_d   = win_vld;
        rom_addr_d = win_vld ? win_addr : rom_addr_q;
        v1_d       = gnt;
        v2_d       = v1_q;

        if (own_hit) begin
            // MAX_BURST must fit the 4-bit counter; it saturates rather than wraps.
            if (32'(bcnt_q) < MAX_BURST) bcnt_d = bcnt_q + 4'd1;
        end else if (rr_found) begin
            own_vld_d = bus.lock[rr_idx];
            own_idx_d = rr_idx;
            bcnt_d    = 4'd1;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            ptr_d     = IdxW'((32'(rr_idx) + 1) % N_REQ);
`endif
        end

        if (new_frame) begin
            own_vld_d = 1'b0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            ptr_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            own_vld_q  <= 1'b0;
            own_idx_q  <= '0;
            bcnt_q     <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            ptr_q      <= '0;
`endif
        end else begin
            own_vld_q  <= own_vld_d;
            own_idx_q  <= own_idx_d;
            bcnt_q     <= bcnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign bus.gnt      = gnt;
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rvalid   = v2_q;
    assign bus.rdata    = bus.rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed-vector bench for sprite_rom_arbiter with a 1-cycle synchronous ROM model.
module tb_sprite_rom_arbiter;

    localparam logic [13:0] A0 = 14'h100;
    localparam logic [13:0] A2 = 14'h300;
    localparam logic [13:0] A3 = 14'h400;

    typedef struct packed {
        logic        rst;
        logic        nf;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [13:0] a1;
        logic [3:0]  gnt;
        logic        en;
        logic [13:0] addr;
        logic [3:0]  rv;
        logic [15:0] rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic new_frame = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tv[$];

    sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(14), .DATA_W(16)) bus ();

    sprite_rom_arbiter #(
        .N_REQ    (4),
        .ADDR_W   (14),
        .DATA_W   (16),
        .MAX_BURST(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .new_frame(new_frame),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_f(input logic [13:0] a);
        return {2'b00, a} ^ 16'h5A5A;
    endfunction

    initial bus.rom_data = '0;
    always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom_f(bus.rom_addr);

    function automatic vec_t mk(input logic r, input logic nf, input logic [3:0] rq,
                                input logic [3:0] lk, input logic [13:0] a1,
                                input logic [3:0] g, input logic en, input logic [13:0] ad,
                                input logic [3:0] rv, input logic [15:0] rd);
        vec_t v;
        v.rst = r; v.nf = nf; v.req = rq; v.lock = lk; v.a1 = a1;
        v.gnt = g; v.en = en; v.addr = ad; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic nf, input logic [3:0] rq,
                         input logic [3:0] lk, input logic [13:0] a1);
        rst          = r;
        new_frame    = nf;
        bus.req      = rq;
        bus.lock     = lk;
        bus.req_addr = {A3, A2, a1, A0};
    endtask

    initial begin
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 14'h200);
        repeat (2) @(posedge clk);

`ifndef SPRITE_ARB_FIXED_PRIO_EN
        // Alternating winners, no lock.
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, 14'h000, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0101, 4'b0000, 14'h200, 4'b0001, 0, 14'h000, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0101, 4'b0000, 14'h200, 4'b0100, 1, A0, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0101, 4'b0000, 14'h200, 4'b0001, 1, A2, 4'b0001, rom_f(A0)));
        tv.push_back(mk(0, 0, 4'b0101, 4'b0000, 14'h200, 4'b0100, 1, A0, 4'b0100, rom_f(A2)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 1, A2, 4'b0001, rom_f(A0)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, A2, 4'b0100, rom_f(A2)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, A2, 4'b0000, 16'h0));
        // Single requester streaming addresses 10, 11, 12.
        tv.push_back(mk(0, 0, 4'b0010, 4'b0000, 14'd10, 4'b0010, 0, A2, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0010, 4'b0000, 14'd11, 4'b0010, 1, 14'd10, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0010, 4'b0000, 14'd12, 4'b0010, 1, 14'd11, 4'b0010,
                        rom_f(14'd10)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'd12, 4'b0000, 1, 14'd12, 4'b0010,
                        rom_f(14'd11)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'd12, 4'b0000, 0, 14'd12, 4'b0010,
                        rom_f(14'd12)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'd12, 4'b0000, 0, 14'd12, 4'b0000, 16'h0));
        // Move ptr to 1, then requester 1 locks: 8 beats, one beat to 0, then 1 again.
        tv.push_back(mk(0, 0, 4'b0001, 4'b0000, 14'h200, 4'b0001, 0, 14'd12, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0011, 4'b0010, 14'h200, 4'b0010, 1, A0, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0011, 4'b0010, 14'h200, 4'b0010, 1, 14'h200, 4'b0001, rom_f(A0)));
        for (int i = 0; i < 6; i++)
            tv.push_back(mk(0, 0, 4'b0011, 4'b0010, 14'h200, 4'b0010, 1, 14'h200, 4'b0010,
                            rom_f(14'h200)));
        tv.push_back(mk(0, 0, 4'b0011, 4'b0010, 14'h200, 4'b0001, 1, 14'h200, 4'b0010,
                        rom_f(14'h200)));
        tv.push_back(mk(0, 0, 4'b0011, 4'b0010, 14'h200, 4'b0010, 1, A0, 4'b0010,
                        rom_f(14'h200)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 1, 14'h200, 4'b0001, rom_f(A0)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, 14'h200, 4'b0010,
                        rom_f(14'h200)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, 14'h200, 4'b0000, 16'h0));
        // Locked burst on 3 cut short by new_frame; 2 wins from ptr=0.
        tv.push_back(mk(0, 0, 4'b1100, 4'b1000, 14'h200, 4'b0100, 0, 14'h200, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b1100, 4'b1000, 14'h200, 4'b1000, 1, A2, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b1100, 4'b1000, 14'h200, 4'b1000, 1, A3, 4'b0100, rom_f(A2)));
        tv.push_back(mk(0, 1, 4'b1100, 4'b1000, 14'h200, 4'b1000, 1, A3, 4'b1000, rom_f(A3)));
        tv.push_back(mk(0, 0, 4'b1100, 4'b1000, 14'h200, 4'b0100, 1, A3, 4'b1000, rom_f(A3)));
        tv.push_back(mk(0, 0, 4'b1100, 4'b1000, 14'h200, 4'b1000, 1, A2, 4'b1000, rom_f(A3)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 1, A3, 4'b0100, rom_f(A2)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, A3, 4'b1000, rom_f(A3)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, A3, 4'b0000, 16'h0));
        // new_frame resets ptr: after 2 wins, 1 is next rather than 3.
        tv.push_back(mk(0, 0, 4'b1110, 4'b0000, 14'h200, 4'b0010, 0, A3, 4'b0000, 16'h0));
        tv.push_back(mk(0, 1, 4'b1110, 4'b0000, 14'h200, 4'b0100, 1, 14'h200, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b1110, 4'b0000, 14'h200, 4'b0010, 1, A2, 4'b0010,
                        rom_f(14'h200)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 1, 14'h200, 4'b0100, rom_f(A2)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, 14'h200, 4'b0010,
                        rom_f(14'h200)));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, 14'h200, 4'b0000, 16'h0));
        // Reset one cycle after a grant drops the in-flight beat.
        tv.push_back(mk(0, 0, 4'b0001, 4'b0000, 14'h200, 4'b0001, 0, 14'h200, 4'b0000, 16'h0));
        tv.push_back(mk(1, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 1, A0, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, 14'h000, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b1010, 4'b0000, 14'h200, 4'b0010, 0, 14'h000, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 1, 14'h200, 4'b0000, 16'h0));
        tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 14'h200, 4'b0000, 0, 14'h200, 4'b0010,
                        rom_f(14'h200)));

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].nf, tv[i].req, tv[i].lock, tv[i].a1);
            #1;
            chk($sformatf("gnt[%0d]", i), 32'(bus.gnt), 32'(tv[i].gnt));
            chk($sformatf("rom_en[%0d]", i), 32'(bus.rom_en), 32'(tv[i].en));
            chk($sformatf("rom_addr[%0d]", i), 32'(bus.rom_addr), 32'(tv[i].addr));
            chk($sformatf("rvalid[%0d]", i), 32'(bus.rvalid), 32'(tv[i].rv));
            if (tv[i].rv != 4'b0000)
                chk($sformatf("rdata[%0d]", i), 32'(bus.rdata), 32'(tv[i].rd));
        end

        // Both requesters locked, ptr=2: bursts of exactly 8, alternating 0 and 1.
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'b0011, 4'b0011, 14'h200);
            #1;
            chk($sformatf("burst_gnt[%0d]", k), 32'(bus.gnt),
                ((k / 8) % 2 == 0) ? 32'h1 : 32'h2);
        end
`else
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 14'h200);
        #1;
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
        chk("reset_rom_en", 32'(bus.rom_en), 32'h0);
        chk("reset_rvalid", 32'(bus.rvalid), 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'b1111, 4'b0000, 14'h200);
            #1;
            chk($sformatf("fixed_gnt[%0d]", k), 32'(bus.gnt), 32'h1);
        end
        // Burst limit releases 0, but fixed priority hands it straight back.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 4'b0011, 4'b0011, 14'h200);
            #1;
            chk($sformatf("fixed_burst_gnt[%0d]", k), 32'(bus.gnt), 32'h1);
        end
`endif

        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 14'h200);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
